// File: rtl/sh_mem_pkg.sv
// Shared types and helpers for the SH-style data memory responder.
package sh_mem_pkg;

  localparam int unsigned NumLanes = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } resp_state_t;

  // Size/alignment part of the address-error check; range is checked by the responder.
  function automatic logic align_err(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: align_err = 1'b0;
      SZ_WORD: align_err = addr_lo[0];
      SZ_LONG: align_err = (addr_lo != 2'b00);
      default: align_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sh_mem_lane_align.sv
// Big-endian byte-lane steering: store lane enables/data and sign-extended load extraction.
module sh_mem_lane_align
  import sh_mem_pkg::*;
(
  input  mem_size_t             size,
  input  logic [1:0]            addr_lo,
  input  logic [31:0]           wdata,
  input  logic [31:0]           ram_word,
  output logic [NumLanes-1:0]   lane_we,
  output logic [31:0]           wdata_lanes,
  output logic [31:0]           rdata_ext
);

  logic [7:0] byte_sel;

  // Lane 3 ([31:24]) holds byte offset 0.
  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = ram_word[31:24];
      2'd1:    byte_sel = ram_word[23:16];
      2'd2:    byte_sel = ram_word[15:8];
      default: byte_sel = ram_word[7:0];
    endcase
  end

  always_comb begin
    lane_we     = '0;
    wdata_lanes = wdata;
    rdata_ext   = '0;
    unique case (size)
      SZ_BYTE: begin
        lane_we     = 4'b1000 >> addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_WORD: begin
        lane_we     = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = addr_lo[1] ? {{16{ram_word[15]}}, ram_word[15:0]}
                                 : {{16{ram_word[31]}}, ram_word[31:16]};
      end
      SZ_LONG: begin
        lane_we   = 4'b1111;
        rdata_ext = ram_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sh_data_mem_responder.sv
// Single-outstanding load/store responder with wait states over a big-endian byte-lane RAM.
module sh_data_mem_responder
  import sh_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IdxW     = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam int unsigned Depth    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  mem_size_t   size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [NumLanes-1:0][7:0] ram [Depth];

  logic                acc_we;
  mem_size_t           acc_size;
  logic [31:0]         acc_addr;
  logic [31:0]         acc_wdata;
  logic                acc_err;
  logic                commit;
  logic [IdxW-1:0]     idx;
  logic [31:0]         ram_word;
  logic [NumLanes-1:0] lane_we;
  logic [31:0]         wdata_lanes;
  logic [31:0]         rdata_ext;

  assign req_ready = (state_q == StIdle);

  // With zero wait states the access commits on the accept edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_size  = mem_size_t'(req_size);
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_err  = align_err(acc_size, acc_addr[1:0]) || ((acc_addr >> ADDR_WIDTH) != 32'd0);
  assign idx      = IdxW'(acc_addr >> 2);
  assign ram_word = ram[idx];
  assign commit   = ((state_q == StIdle) && req_valid && (WAIT_STATES == 0)) ||
                    ((state_q == StWait) && (cnt_q == '0));

  sh_mem_lane_align u_align (
    .size        (acc_size),
    .addr_lo     (acc_addr[1:0]),
    .wdata       (acc_wdata),
    .ram_word    (ram_word),
    .lane_we     (lane_we),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  // Reset wins over commit so a store still in WAIT is dropped.
  always_ff @(posedge clk) begin
    if (!reset && commit && acc_we && !acc_err) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (lane_we[l]) ram[idx][l] <= wdata_lanes[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? '0 : rdata_ext;
      end
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= mem_size_t'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) state_q <= StResp;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sh_data_mem_responder.sv
// Bench for sh_data_mem_responder: one instance with 1 wait state, one with 3.
module tb_sh_data_mem_responder;

  localparam int unsigned Ws0 = 1;
  localparam int unsigned Ws1 = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  sh_data_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(Ws0)) u_dut0 (
    .clk       (clk),
    .reset     (reset[0]),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_we    (req_we[0]),
    .req_size  (req_size[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  sh_data_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(Ws1)) u_dut1 (
    .clk       (clk),
    .reset     (reset[1]),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_we    (req_we[1]),
    .req_size  (req_size[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue(input int d, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input string nm);
    int n = 0;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    req_we[d]    = we;
    req_size[d]  = size;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk({nm, " accept timeout"}, 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input string nm);
    int n = 0;
    while (!rsp_valid[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), (d == 0) ? 32'(Ws0) : 32'(Ws1));
  endtask

  task automatic finish_rsp(input int d, input string nm);
    exp_t e;
    e = sb.pop_front();
    chk({nm, " rdata"}, rsp_rdata[d], e.rdata);
    chk({nm, " err"}, {31'b0, rsp_err[d]}, {31'b0, e.err});
    if (rsp_ready[d]) begin
      @(posedge clk); #1;
      chk({nm, " valid drop"}, {31'b0, rsp_valid[d]}, 32'd0);
      chk({nm, " ready back"}, {31'b0, req_ready[d]}, 32'd1);
    end
  endtask

  task automatic do_txn(input int d, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string nm);
    issue(d, we, size, addr, wdata, exp_rdata, exp_err, nm);
    wait_rsp(d, nm);
    finish_rsp(d, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_size[d]  = 2'b00;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d valid", d), {31'b0, rsp_valid[d]}, 32'd0);
      chk($sformatf("rst%0d ready", d), {31'b0, req_ready[d]}, 32'd1);
      chk($sformatf("rst%0d rdata", d), rsp_rdata[d], 32'd0);
      chk($sformatf("rst%0d err", d), {31'b0, rsp_err[d]}, 32'd0);
    end

    // we, size, addr, wdata, expected rdata, expected err
    vecs.push_back('{1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 32'h11, 32'h0, 32'hFFFFFFAD, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 32'h12, 32'h0, 32'hFFFFFFBE, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 32'h10, 32'h0, 32'hFFFFDEAD, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 32'h11, 32'hAAAAAA7F, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 32'h11, 32'h0, 32'h0000007F, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 32'h12, 32'h55551234, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7F1234, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 32'h12, 32'h0, 32'h00001234, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 32'h12, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 2'b01, 32'h13, 32'h0000FFFF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7F1234, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 2'b00, 32'h80000010, 32'h0, 32'h0, 1'b1});

    foreach (vecs[i]) begin
      do_txn(0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Backpressure: response held while a competing store is presented.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7F1234, 1'b0, "bp");
    wait_rsp(0, "bp");
    e = sb.pop_front();
    req_we[0]    = 1'b1;
    req_size[0]  = 2'b10;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d valid", i), {31'b0, rsp_valid[0]}, 32'd1);
      chk($sformatf("bp%0d rdata", i), rsp_rdata[0], e.rdata);
      chk($sformatf("bp%0d err", i), {31'b0, rsp_err[0]}, {31'b0, e.err});
      chk($sformatf("bp%0d req_ready", i), {31'b0, req_ready[0]}, 32'd0);
      if (i == 4) req_valid[0] = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", {31'b0, rsp_valid[0]}, 32'd0);
    chk("bp release ready", {31'b0, req_ready[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no stray rsp", {31'b0, rsp_valid[0]}, 32'd0);
    do_txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7F1234, 1'b0, "bp after");

    // Reset in WAIT with three wait states drops the pending store.
    do_txn(1, 1'b1, 2'b10, 32'h10, 32'hDE7F1234, 32'h0, 1'b0, "w3 seed");
    do_txn(1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7F1234, 1'b0, "w3 load");
    req_we[1]    = 1'b1;
    req_size[1]  = 2'b10;
    req_addr[1]  = 32'h10;
    req_wdata[1] = 32'h0;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("w3 in wait", {31'b0, req_ready[1]}, 32'd0);
    @(posedge clk); #1;
    reset[1] = 1'b1;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    chk("w3 rst valid", {31'b0, rsp_valid[1]}, 32'd0);
    chk("w3 rst ready", {31'b0, req_ready[1]}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("w3 no rsp", {31'b0, rsp_valid[1]}, 32'd0);
    do_txn(1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDE7F1234, 1'b0, "w3 kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
